// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and address map for the APB initiator
package apb_pkg;

  localparam int NSLV_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_DECERR = 2'd3
  } apb_state_e;

  // Each slave owns a 64 MiB window; entry i belongs to psel[i]
  localparam logic [NSLV_DEF-1:0][31:0] SLV_BASE  = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000};
  localparam logic [NSLV_DEF-1:0][31:0] SLV_LIMIT = {32'h8BFF_FFFF, 32'h87FF_FFFF, 32'h83FF_FFFF};

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - request/response stream plus APB2 bus bundle
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = apb_pkg::NSLV_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              pwrite;
  logic              penable;
  logic [NSLV-1:0]   psel;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           pwrite, penable, psel, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           pwrite, penable, psel, paddr, pwdata
  );
endinterface

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational address to one-hot slave select
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NSLV   = NSLV_DEF
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NSLV-1:0]   sel_o,
  output logic              hit_o
);

  for (genvar i = 0; i < NSLV; i++) begin : g_sel
    assign sel_o[i] = (addr_i >= ADDR_W'(SLV_BASE[i])) && (addr_i <= ADDR_W'(SLV_LIMIT[i]));
  end

  assign hit_o = |sel_o;

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready request stream to APB2 transfers
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = NSLV_DEF
) (
  input  logic         hclk,
  input  logic         hreset,
  apb_master_if.master bus
);

  apb_state_e        state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              pwrite_q;
  logic              penable_q;
  logic [NSLV-1:0]   psel_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [NSLV-1:0]   dec_sel;
  logic              dec_hit;
  logic              accept;

  apb_addr_decode #(.ADDR_W(ADDR_W), .NSLV(NSLV)) u_dec (
    .addr_i (bus.req_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  assign accept = bus.req_valid && req_ready_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      psel_q      <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (accept) begin
        paddr_q  <= bus.req_addr;
        pwdata_q <= bus.req_wdata;
        pwrite_q <= bus.req_write;
      end
      case (state_q)
        ST_SETUP: begin
          state_q     <= ST_ENABLE;
          penable_q   <= 1'b1;
          req_ready_q <= 1'b1;
        end
        ST_DECERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          // ENABLE completes here; pwrite_q still describes the finishing transfer
          if (state_q == ST_ENABLE) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
          end
          penable_q <= 1'b0;
          if (accept && dec_hit) begin
            state_q     <= ST_SETUP;
            psel_q      <= dec_sel;
            req_ready_q <= 1'b0;
          end else if (accept) begin
            state_q     <= ST_DECERR;
            psel_q      <= '0;
            req_ready_q <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.penable   = penable_q;
  assign bus.psel      = psel_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

  logic hclk = 1'b0;
  logic hreset;
  int   checks = 0;
  int   failures = 0;

  logic        rd_fixed;
  logic [31:0] rd_val;

  apb_master_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();

  apb_master #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.master)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Slave drives real data only during ENABLE, garbage otherwise
  always_comb begin
    if (bus.penable && (bus.psel != 3'b000))
      bus.prdata = rd_fixed ? rd_val : slave_word(bus.paddr);
    else
      bus.prdata = 32'hBADB_AD00;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdv;
    logic [2:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  sel;
  } exp_t;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_sel(input logic [31:0] a);
    logic [31:0] idx;
    if (a < 32'h8000_0000) return 3'b000;
    idx = (a - 32'h8000_0000) / 32'h0400_0000;
    if (idx < 3) return 3'(1 << idx);
    return 3'b000;
  endfunction

  task automatic run_vec(input vec_t v);
    rd_fixed = 1'b1;
    rd_val   = v.rdv;
    chk("vec_ready_before", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    step();
    bus.req_valid = 1'b0;
    chk("vec_t1_paddr", bus.paddr, v.addr);
    chk("vec_t1_pwdata", bus.pwdata, v.wdata);
    chk("vec_t1_pwrite", 32'(bus.pwrite), 32'(v.wr));
    chk("vec_t1_psel", 32'(bus.psel), 32'(v.sel));
    chk("vec_t1_penable", 32'(bus.penable), 0);
    chk("vec_t1_ready", 32'(bus.req_ready), 0);
    chk("vec_t1_rsp", 32'(bus.rsp_valid), 0);
    if (!v.err) begin
      step();
      chk("vec_t2_psel", 32'(bus.psel), 32'(v.sel));
      chk("vec_t2_penable", 32'(bus.penable), 1);
      chk("vec_t2_rsp", 32'(bus.rsp_valid), 0);
    end
    step();
    chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("vec_rsp_err", 32'(bus.rsp_err), 32'(v.err));
    chk("vec_rsp_rdata", bus.rsp_rdata, v.rdata);
    chk("vec_rsp_psel", 32'(bus.psel), 0);
    chk("vec_rsp_penable", 32'(bus.penable), 0);
    chk("vec_rsp_ready", 32'(bus.req_ready), 1);
    step();
    chk("vec_rsp_drop", 32'(bus.rsp_valid), 0);
  endtask

  task automatic back_to_back();
    rd_fixed = 1'b1;
    rd_val   = 32'h0F1E_2D3C;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h8000_0000;
    bus.req_wdata = 32'h0;
    step();
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h8000_0004;
    bus.req_wdata = 32'h7777_8888;
    chk("b2b_setup1", {28'd0, bus.psel, bus.penable}, 32'b0010);
    step();
    chk("b2b_enable1", {28'd0, bus.psel, bus.penable}, 32'b0011);
    chk("b2b_ready_enable", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 1'b0;
    chk("b2b_setup2", {28'd0, bus.psel, bus.penable}, 32'b0010);
    chk("b2b_rsp1_valid", 32'(bus.rsp_valid), 1);
    chk("b2b_rsp1_rdata", bus.rsp_rdata, 32'h0F1E_2D3C);
    chk("b2b_setup2_paddr", bus.paddr, 32'h8000_0004);
    step();
    chk("b2b_enable2", {28'd0, bus.psel, bus.penable}, 32'b0011);
    chk("b2b_rsp_gap", 32'(bus.rsp_valid), 0);
    step();
    chk("b2b_rsp2_valid", 32'(bus.rsp_valid), 1);
    chk("b2b_rsp2_rdata", bus.rsp_rdata, 32'h0);
    chk("b2b_idle_psel", 32'(bus.psel), 0);
  endtask

  task automatic reset_mid_enable();
    rd_fixed = 1'b1;
    rd_val   = 32'hAAAA_5555;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h8400_0008;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rst_mid_in_enable", 32'(bus.penable), 1);
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    chk("rst_mid_psel", 32'(bus.psel), 0);
    chk("rst_mid_penable", 32'(bus.penable), 0);
    chk("rst_mid_rsp", 32'(bus.rsp_valid), 0);
    chk("rst_mid_paddr", bus.paddr, 0);
    chk("rst_mid_ready", 32'(bus.req_ready), 1);
    step();
    chk("rst_mid_no_ghost", 32'(bus.rsp_valid), 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 5);
    if (r < 3) return 32'h8000_0000 + (32'(r) << 26) + ($urandom() & 32'h03FF_FFFF);
    if (r == 3) return $urandom();
    if (r == 4) return 32'h8000_0000 + (32'($urandom_range(0, 3)) << 26) - 32'($urandom_range(0, 1));
    return 32'h8C00_0000 + 32'($urandom_range(0, 255));
  endfunction

  task automatic run_random(input int n);
    exp_t        q[$];
    exp_t        e;
    int          sent = 0;
    int          cyc = 0;
    logic [2:0]  prev_psel = 3'b000;
    logic        prev_pen = 1'b0;
    logic        acc;
    logic [2:0]  s;
    rd_fixed = 1'b0;
    bus.req_valid = 1'b0;
    while ((sent < n || q.size() != 0) && cyc < 20000) begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_rsp", 32'(bus.rsp_valid), 0);
        end else begin
          e = q.pop_front();
          chk("rnd_rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("rnd_rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rnd_rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end
      if (bus.penable) begin
        chk("rnd_pen_after_setup", {30'd0, prev_pen, (prev_psel == bus.psel && prev_psel != 3'b000)}, 32'b01);
        if (q.size() != 0) chk("rnd_enable_psel", 32'(bus.psel), 32'(q[0].sel));
      end
      if (!bus.req_valid && sent < n && $urandom_range(0, 2) != 0) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = rand_addr();
        bus.req_wdata = $urandom();
      end
      acc = bus.req_valid && bus.req_ready;
      if (acc) begin
        s = model_sel(bus.req_addr);
        e.sel   = s;
        e.err   = (s == 3'b000);
        e.cyc   = cyc + (e.err ? 2 : 3);
        e.rdata = (e.err || bus.req_write) ? 32'h0 : slave_word(bus.req_addr);
        q.push_back(e);
        sent++;
      end
      prev_psel = bus.psel;
      prev_pen  = bus.penable;
      step();
      cyc++;
      if (acc) bus.req_valid = 1'b0;
    end
    if (cyc >= 20000) chk("rnd_timeout", 0, 1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 32'h8400_0010, 32'hDEAD_BEEF, 32'h0,         3'b010, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h8800_0004, 32'h0,         32'h1234_5678, 3'b100, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h5555_0000, 32'hA5A5_0001, 3'b001, 1'b0, 32'hA5A5_0001};
    vecs[3] = '{1'b0, 32'h83FF_FFFF, 32'h0,         32'h0000_0083, 3'b001, 1'b0, 32'h0000_0083};
    vecs[4] = '{1'b1, 32'h8400_0000, 32'h1111_2222, 32'h9999_9999, 3'b010, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h8BFF_FFFC, 32'h0,         32'hCAFE_0002, 3'b100, 1'b0, 32'hCAFE_0002};
    vecs[6] = '{1'b0, 32'h9000_0000, 32'h0,         32'hFFFF_FFFF, 3'b000, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 32'h8C00_0000, 32'h3333_4444, 32'hFFFF_FFFF, 3'b000, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'h7FFF_FFFF, 32'h0,         32'hFFFF_FFFF, 3'b000, 1'b1, 32'h0};

    hreset        = 1'b1;
    rd_fixed      = 1'b1;
    rd_val        = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    step();
    step();
    chk("reset_ready", 32'(bus.req_ready), 1);
    chk("reset_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.pwrite}, 0);
    chk("reset_bus", {28'd0, bus.psel, bus.penable}, 0);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);
    chk("reset_rdata", bus.rsp_rdata, 0);
    hreset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    back_to_back();
    step();
    reset_mid_enable();
    run_vec(vecs[1]);
    run_random(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
